// File: rtl/solo_squash_pkg.sv
// Shared constants for the solo squash button front end.
package solo_squash_pkg;

  localparam int NUM_BTNS = 5;

  localparam int BTN_EXT_RESET = 0;
  localparam int BTN_PAUSE     = 1;
  localparam int BTN_NEW_GAME  = 2;
  localparam int BTN_DOWN      = 3;
  localparam int BTN_UP        = 4;

endpackage

// File: rtl/solo_squash_debounce_chan.sv
// One button channel: synchroniser chain, debounce counter, stable level and edge pulses.
module solo_squash_debounce_chan #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  // Reset state is "released" everywhere so a held button is seen as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync          <= '1;
      level         <= 1'b1;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync          <= {sync[SYNC_STAGES-2:0], btn_n};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level         <= synced;
        cnt           <= '0;
        press_pulse   <= ~synced;
        release_pulse <= synced;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/solo_squash_input_conditioner.sv
// Button conditioning for solo squash: one independent debounce channel per pad.
module solo_squash_input_conditioner
  import solo_squash_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                wb_clk_i,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_n_i,
  output logic [NUM_BTNS-1:0] btn_n_o,
  output logic [NUM_BTNS-1:0] btn_press_o,
  output logic [NUM_BTNS-1:0] btn_release_o
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be in 2..4");
  end

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    solo_squash_debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk           (wb_clk_i),
      .rst_n         (rst_n),
      .btn_n         (btn_n_i[i]),
      .level         (btn_n_o[i]),
      .press_pulse   (btn_press_o[i]),
      .release_pulse (btn_release_o[i])
    );
  end

endmodule

// File: tb/tb_solo_squash_input_conditioner.sv
// Directed and randomised-bounce bench for solo_squash_input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_solo_squash_input_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic       clk;
  logic       rst_n;
  logic [4:0] btn_n_i;
  logic [4:0] btn_n_o;
  logic [4:0] btn_press_o;
  logic [4:0] btn_release_o;

  int n_checks;
  int n_errors;

  solo_squash_input_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .wb_clk_i      (clk),
    .rst_n         (rst_n),
    .btn_n_i       (btn_n_i),
    .btn_n_o       (btn_n_o),
    .btn_press_o   (btn_press_o),
    .btn_release_o (btn_release_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got[4:0], exp[4:0]);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [4:0] lvl,
                            input logic [4:0] prs, input logic [4:0] rel);
    check({tag, " level"},   btn_n_o,       lvl);
    check({tag, " press"},   btn_press_o,   prs);
    check({tag, " release"}, btn_release_o, rel);
  endtask

  logic [4:0] h0, h1, h2, model_lvl, model_prs, model_rel, r, target, prev_lvl;
  int         run [5];
  int         pulse_total, trans_total;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    btn_n_i  = 5'b00000;

    // Reset held with every pad pressed.
    tick(1);
    check_outs("reset a", 5'b11111, 5'b00000, 5'b00000);
    tick(2);
    check_outs("reset b", 5'b11111, 5'b00000, 5'b00000);
    rst_n = 1'b1;
    tick(5);
    check_outs("post-reset 5", 5'b11111, 5'b00000, 5'b00000);
    tick(1);
    check_outs("post-reset 6", 5'b00000, 5'b11111, 5'b00000);
    tick(1);
    check_outs("post-reset 7", 5'b00000, 5'b00000, 5'b00000);

    // All released together.
    btn_n_i = 5'b11111;
    tick(5);
    check_outs("all rel 5", 5'b00000, 5'b00000, 5'b00000);
    tick(1);
    check_outs("all rel 6", 5'b11111, 5'b00000, 5'b11111);
    tick(1);
    check_outs("all rel 7", 5'b11111, 5'b00000, 5'b00000);

    // Clean step on bit 2.
    btn_n_i = 5'b11011;
    tick(5);
    check_outs("bit2 5", 5'b11111, 5'b00000, 5'b00000);
    tick(1);
    check_outs("bit2 6", 5'b11011, 5'b00100, 5'b00000);
    tick(1);
    check_outs("bit2 7", 5'b11011, 5'b00000, 5'b00000);
    btn_n_i = 5'b11111;
    tick(8);
    check_outs("bit2 restore", 5'b11111, 5'b00000, 5'b00000);

    // Bounce on bit 0: low 3, high 1, then held low.
    btn_n_i = 5'b11110;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      check_outs($sformatf("bounce low %0d", i), 5'b11111, 5'b00000, 5'b00000);
    end
    btn_n_i = 5'b11111;
    tick(1);
    check_outs("bounce high", 5'b11111, 5'b00000, 5'b00000);
    btn_n_i = 5'b11110;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      check_outs($sformatf("bounce final %0d", i),
                 (i >= 6) ? 5'b11110 : 5'b11111,
                 (i == 6) ? 5'b00001 : 5'b00000, 5'b00000);
    end
    btn_n_i = 5'b11111;
    tick(8);

    // Bit 4 held then released.
    btn_n_i = 5'b01111;
    tick(8);
    check_outs("bit4 held", 5'b01111, 5'b00000, 5'b00000);
    btn_n_i = 5'b11111;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      check_outs($sformatf("bit4 rel %0d", i),
                 (i >= 6) ? 5'b11111 : 5'b01111,
                 5'b00000, (i == 6) ? 5'b10000 : 5'b00000);
    end

    // Reset while bit 3 has counted to 2.
    btn_n_i = 5'b10111;
    tick(4);
    rst_n = 1'b0;
    #1;
    check_outs("midcount rst", 5'b11111, 5'b00000, 5'b00000);
    tick(2);
    check_outs("midcount rst held", 5'b11111, 5'b00000, 5'b00000);
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      check_outs($sformatf("reaccept %0d", i),
                 (i >= 6) ? 5'b10111 : 5'b11111,
                 (i == 6) ? 5'b01000 : 5'b00000, 5'b00000);
    end
    btn_n_i = 5'b11111;
    tick(8);

    // Randomised bounce against a run-length reference.
    h0 = 5'b11111;
    h1 = 5'b11111;
    model_lvl = 5'b11111;
    prev_lvl  = btn_n_o;
    for (int b = 0; b < 5; b++) run[b] = 0;
    pulse_total = 0;
    trans_total = 0;
    target = 5'b11111;
    for (int seg = 0; seg < 24; seg++) begin
      if (seg % 2 == 0) target = 5'($urandom);
      for (int c = 0; c < 10; c++) begin
        r = (seg % 2 == 0) ? 5'($urandom) : target;
        btn_n_i = r;
        h2 = h1;
        h1 = h0;
        h0 = r;
        tick(1);
        model_prs = '0;
        model_rel = '0;
        for (int b = 0; b < 5; b++) begin
          if (h2[b] != model_lvl[b]) begin
            run[b]++;
            if (run[b] == DEB) begin
              model_lvl[b] = h2[b];
              run[b] = 0;
              if (h2[b]) model_rel[b] = 1'b1;
              else       model_prs[b] = 1'b1;
            end
          end else begin
            run[b] = 0;
          end
        end
        check_outs($sformatf("rand s%0d c%0d", seg, c), model_lvl, model_prs, model_rel);
        check($sformatf("rand overlap s%0d c%0d", seg, c), btn_press_o & btn_release_o, 5'b00000);
        check($sformatf("rand pulse-edge s%0d c%0d", seg, c),
              btn_press_o | btn_release_o, btn_n_o ^ prev_lvl);
        pulse_total += $countones(btn_press_o) + $countones(btn_release_o);
        trans_total += $countones(btn_n_o ^ prev_lvl);
        prev_lvl = btn_n_o;
      end
    end
    check("rand pulse total", pulse_total, trans_total);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/solo_squash_input_conditioner.md
SOLO_SQUASH_INPUT_CONDITIONER -- requirements
Module: solo_squash_input_conditioner

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchroniser flops per button (legal values 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250000, the consecutive stable synchronised cycles needed to accept a change (legal values >= 2; 10 ms at 25 MHz).
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port btn_n_i, input, 5 bits: raw active-low pads; bit 0 ext_reset_n, 1 pause_n, 2 new_game_n, 3 down_key_n, 4 up_key_n (pads io_in[8..12]).
REQ-006 SHALL have port btn_n_o, output, 5 bits: debounced active-low level per button, same bit order.
REQ-007 SHALL have port btn_press_o, output, 5 bits: one-cycle pulse on each accepted high-to-low transition.
REQ-008 SHALL have port btn_release_o, output, 5 bits: one-cycle pulse on each accepted low-to-high transition.

Function
REQ-009 Each bit of btn_n_i SHALL pass through a SYNC_STAGES-deep flop chain before any other use.
REQ-010 Each channel SHALL hold a stable state S (drives btn_n_o) and a counter C of width clog2(DEBOUNCE_CYCLES).
REQ-011 When synchronised input equals S, C SHALL clear to 0 in the next cycle.
REQ-012 When synchronised input differs from S and C < DEBOUNCE_CYCLES-1, C SHALL increment by 1.
REQ-013 When synchronised input differs from S and C == DEBOUNCE_CYCLES-1, S SHALL take the synchronised value, C SHALL clear, and the matching press/release bit SHALL assert for exactly that cycle.
REQ-014 Any glitch back to S before acceptance SHALL clear C, so no partial count carries over.
REQ-015 C SHALL never wrap, saturate or exceed DEBOUNCE_CYCLES-1.
REQ-016 Latency for a clean step on btn_n_i at edge 0 SHALL be SYNC_STAGES + DEBOUNCE_CYCLES cycles to the btn_n_o change and pulse.
REQ-017 Channels SHALL be fully independent, and simultaneous transitions on several bits SHALL pulse in the same cycle.
REQ-018 btn_press_o[i] and btn_release_o[i] SHALL never be asserted together, and each SHALL be asserted only in the cycle btn_n_o[i] changes.
REQ-019 All outputs SHALL be registered, with no combinational path from btn_n_i to any output.

Reset
REQ-020 On rst_n low, all synchroniser flops and btn_n_o SHALL go to 1 (released), C to 0, and btn_press_o and btn_release_o to 0, asynchronously.
REQ-021 Reset asserted mid-count SHALL discard the count, and no pulse SHALL be emitted for it.
REQ-022 After rst_n rises, a button already held low SHALL be accepted as a normal press after SYNC_STAGES + DEBOUNCE_CYCLES cycles, with one press pulse.

Structure
REQ-023 The shared package solo_squash_pkg SHALL hold NUM_BTNS = 5 and the button index constants BTN_EXT_RESET = 0 through BTN_UP = 4.
REQ-024 The per-button synchroniser, counter and stable state SHALL live in the sub-module solo_squash_debounce_chan, instantiated NUM_BTNS times.
REQ-025 The top level SHALL contain only parameter checks and instance wiring.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-026 Reset with btn_n_i=00000 -> btn_n_o=11111 and pulses 00000 throughout reset; after rst_n rises, btn_n_o=00000 and btn_press_o=11111 for one cycle, 6 cycles later.
REQ-027 Bit 2 steps low at edge 0 -> btn_n_o=11011 and btn_press_o=00100 at edge 6 only; other bits unchanged.
REQ-028 Bit 0 low 3 cycles, high 1 cycle, then low held -> no pulse during bounce; exactly one btn_press_o[0] pulse, 6 cycles after the final low.
REQ-029 Bit 4 held low then released -> btn_release_o=10000 for one cycle, 6 cycles after release; btn_press_o stays 0.
REQ-030 rst_n pulsed low while bit 3 count is at 2 -> btn_n_o[3]=1, no pulse; re-acceptance takes 6 full cycles after rst_n rises.
REQ-031 Randomised bounce on all 5 bits -> a scoreboard checks REQ-013/015/018 every cycle and that the pulse count matches btn_n_o transitions.
